// File: rtl/npc_ras_unit.sv
// Next-PC stage with the PC register and a circular return-address stack.
// Produces the combinational next PC for all flow ops; the PC and RAS update on the clock.
module npc_ras_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(32'h0000_4180)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [2:0]                   npc_op,
  input  logic [25:0]                  imm,
  input  logic [WIDTH-1:0]             pcjr,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             npc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_underflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    OP_PLUS4  = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_JUMPR  = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5,
    OP_TRAP   = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    tos_q, tos_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pcplus4;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] jmp_tgt;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             push;
  logic             pop;

  assign op        = op_e'(npc_op);
  assign pcplus4   = pc_q + WIDTH'(4);
  assign br_off    = {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
  assign jmp_tgt   = {pcplus4[WIDTH-1:28], imm, 2'b00};
  // tos points at the next free slot, so the live top sits one below it
  assign ras_top   = ras_q[tos_q - PW'(1)];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

  always_comb begin
    npc = pcplus4;
    unique case (op)
      OP_BRANCH:        npc = pcplus4 + br_off;
      OP_JUMP, OP_CALL: npc = jmp_tgt;
      OP_JUMPR:         npc = pcjr;
      OP_RET:           npc = ras_empty ? pcjr : ras_top;
      OP_TRAP:          npc = TRAP_VEC;
      default:          npc = pcplus4;
    endcase
  end

  assign ras_underflow = (op == OP_RET) && ras_empty;
  assign push          = !stall && (op == OP_CALL);
  assign pop           = !stall && (op == OP_RET) && !ras_empty;

  always_comb begin
    pc_d  = stall ? pc_q : npc;
    tos_d = tos_q;
    cnt_d = cnt_q;
    if (push) begin
      tos_d = tos_q + PW'(1);
      // a push into a full stack silently overwrites the oldest entry
      cnt_d = ras_full ? cnt_q : cnt_q + CW'(1);
    end else if (pop) begin
      tos_d = tos_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      tos_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) ras_q[tos_q] <= pcplus4;
  end

  assign pc        = pc_q;
  assign ras_count = cnt_q;

endmodule

// File: doc/npc_ras_unit.md
Name: npc_ras_unit

Overview:
Parametrised next-PC stage for the single-cycle/pipelined MIPS core. It owns the PC register and computes the next PC for sequential, branch, jump, jump-register, call, return and trap flows. An internal return-address stack (RAS) supplies return targets. Sits between the control unit (npc_op) and instruction memory (pc).

Parameters:
WIDTH, 32, address width in bits; must be ≥ 32.
RAS_DEPTH, 8, number of RAS entries; power of two, ≥ 2.
RESET_PC, 32'h0000_3000, PC value loaded on reset.
TRAP_VEC, 32'h0000_4180, target address for the TRAP operation.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
stall  in  1  1 = hold PC and RAS this cycle
npc_op  in  3  0 PLUS4, 1 BRANCH, 2 JUMP, 3 JUMPR, 4 CALL, 5 RET, 6 TRAP, 7 reserved (treated as PLUS4)
imm  in  26  instruction immediate field; [15:0] is used for BRANCH, [25:0] for JUMP/CALL
pcjr  in  WIDTH  register operand for JUMPR, and fallback target for RET
pc  out  WIDTH  current PC (registered)
npc  out  WIDTH  next PC (combinational)
ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries (registered)
ras_underflow  out  1  combinational; 1 when npc_op=RET and ras_count=0

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC; ras_count=0; top-of-stack pointer=0; RAS entries are don't-care. Reset mid-operation discards the stack contents.
- pcplus4 = pc + 4, computed modulo 2^WIDTH.
- npc is selected combinationally:
  - PLUS4 and reserved op: pcplus4.
  - BRANCH: pcplus4 + sign-extended({imm[15:0],2'b00}) to WIDTH bits; wraps modulo 2^WIDTH.
  - JUMP / CALL: {pcplus4[WIDTH-1:28], imm[25:0], 2'b00}.
  - JUMPR: pcjr.
  - RET: RAS top entry if ras_count>0, else pcjr (ras_underflow=1).
  - TRAP: TRAP_VEC.
- Rising edge with stall=0: pc<=npc, and the RAS is updated as below.
- Rising edge with stall=1: pc, the RAS and ras_count are all held. npc and ras_underflow still reflect the current inputs.
- RAS is circular with pointer tos (index of the next free slot).
  - CALL pushes pcplus4 into entry[tos], then tos<=tos+1 (mod RAS_DEPTH), then ras_count<=min(ras_count+1, RAS_DEPTH).
  - Push when full overwrites the oldest entry; ras_count stays at RAS_DEPTH.
  - RET with ras_count>0: tos<=tos-1 (mod RAS_DEPTH), ras_count<=ras_count-1.
  - RET with ras_count=0: no RAS state change.
  - All other ops leave the RAS unchanged, including TRAP.
- Only one RAS operation occurs per cycle; op encoding makes push and pop mutually exclusive.
- Latency: the new PC is visible on pc one cycle after the op is presented with stall=0.

Test Plan:
- Reset release, PLUS4 ×3 -> pc sequence 0x3000, 0x3004, 0x3008, 0x300C; ras_count=0 throughout.
- pc=0x3010, BRANCH, imm=16'hFFFE -> npc=0x300C; next: BRANCH, imm=16'h0004 -> npc=0x3020.
- pc=0x3000, CALL imm=26'h0000400 -> pc=0x1000, ras_count=1; then at 0x1000 RET with pcjr=0xDEAD -> pc=0x3004, ras_count=0, ras_underflow=0.
- RAS_DEPTH=8: 9 nested CALLs from distinct PCs -> ras_count=8; 8 RETs return the 9th..2nd return addresses in order; 9th RET -> ras_underflow=1, npc=pcjr, ras_count stays 0.
- stall=1 with CALL asserted for 3 cycles -> pc and ras_count unchanged; drop stall -> exactly one push occurs.
- CALL, then TRAP -> pc=0x4180 and ras_count=1; assert rst low mid-cycle -> pc=0x3000 and ras_count=0 immediately, without waiting for a clock edge.
